// File: rtl/fu_sequencer.sv
// Multi-pass function-unit sequencer: IDLE accepts an op, EXEC drives the external FU,
// DONE pulses completion. Multi-pass with opb feedback is enabled by FU_SEQ_ITER_EN.
module fu_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   output logic        ready,
   input  logic [3:0]  op,
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   input  logic [3:0]  count,
   output logic [3:0]  fu_fs,
   output logic [15:0] fu_opa,
   output logic [15:0] fu_opb,
   input  logic [15:0] fu_result,
   input  logic        fu_v,
   input  logic        fu_c,
   input  logic        fu_n,
   input  logic        fu_z,
   output logic [15:0] result,
   output logic        v,
   output logic        c,
   output logic        n,
   output logic        z,
   output logic        done,
   output logic        err
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned CNT_W  = 4;
   localparam logic [OP_W-1:0] OP_LAST_LEGAL = OP_W'(12);
   localparam logic [OP_W-1:0] FS_IDLE       = OP_W'(15);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [DATA_W-1:0]   opa_q, opa_d;
   logic [DATA_W-1:0]   opb_q, opb_d;
   logic [CNT_W-1:0]    pass_q, pass_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic [3:0]          vcnz_q, vcnz_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                ready_q, ready_d;
   logic [OP_W-1:0]     fu_fs_q, fu_fs_d;
   logic [DATA_W-1:0]   fu_opa_q, fu_opa_d;
   logic [DATA_W-1:0]   fu_opb_q, fu_opb_d;
   logic [CNT_W-1:0]    passes_c;

`ifdef FU_SEQ_ITER_EN
   assign passes_c = (count == CNT_W'(0)) ? CNT_W'(1) : count;
`else
   logic count_unused;
   assign count_unused = ^count;
   assign passes_c     = CNT_W'(1);
`endif

   // Next-state and datapath; FU drive is registered from the next state.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      pass_d   = pass_q;
      result_d = result_q;
      vcnz_d   = vcnz_q;
      err_d    = err_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               op_d     = op;
               opa_d    = opa;
               opb_d    = opb;
               pass_d   = passes_c;
               result_d = '0;
               vcnz_d   = '0;
               if (op > OP_LAST_LEGAL) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            pass_d = (pass_q != CNT_W'(0)) ? pass_q - CNT_W'(1) : CNT_W'(0);
            if (pass_q <= CNT_W'(1)) begin
               result_d = fu_result;
               vcnz_d   = {fu_v, fu_c, fu_n, fu_z};
               done_d   = 1'b1;
               state_d  = S_DONE;
            end
`ifdef FU_SEQ_ITER_EN
            else begin
               opb_d = fu_result;
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      ready_d  = (state_d == S_IDLE);
      fu_fs_d  = (state_d == S_EXEC) ? op_d  : FS_IDLE;
      fu_opa_d = (state_d == S_EXEC) ? opa_d : '0;
      fu_opb_d = (state_d == S_EXEC) ? opb_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         pass_q   <= '0;
         result_q <= '0;
         vcnz_q   <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b1;
         fu_fs_q  <= FS_IDLE;
         fu_opa_q <= '0;
         fu_opb_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         pass_q   <= pass_d;
         result_q <= result_d;
         vcnz_q   <= vcnz_d;
         done_q   <= done_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
         fu_fs_q  <= fu_fs_d;
         fu_opa_q <= fu_opa_d;
         fu_opb_q <= fu_opb_d;
      end
   end

   assign ready  = ready_q;
   assign fu_fs  = fu_fs_q;
   assign fu_opa = fu_opa_q;
   assign fu_opb = fu_opb_q;
   assign result = result_q;
   assign {v, c, n, z} = vcnz_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule

// File: tb/tb_fu_sequencer.sv
// Self-checking bench for fu_sequencer: transaction-level reference model, a toy
// combinational function unit, directed cases plus randomized traffic.
module tb_fu_sequencer;

   logic        clk = 1'b0;
   logic        rst, req;
   logic [3:0]  op, count;
   logic [15:0] opa, opb;
   logic        ready, done, err, v, c, n, z;
   logic [3:0]  fu_fs;
   logic [15:0] fu_opa, fu_opb, fu_result, result;
   logic        fu_v, fu_c, fu_n, fu_z;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fu_sequencer dut (
      .clk(clk), .rst(rst), .req(req), .ready(ready), .op(op), .opa(opa), .opb(opb),
      .count(count), .fu_fs(fu_fs), .fu_opa(fu_opa), .fu_opb(fu_opb),
      .fu_result(fu_result), .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z),
      .result(result), .v(v), .c(c), .n(n), .z(z), .done(done), .err(err)
   );

   // Toy function unit, returns {v,c,n,z,result}
   function automatic logic [19:0] fu_func(input logic [3:0] f, input logic [15:0] a,
                                          input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic        cy, ov;
      s = '0; cy = 1'b0; ov = 1'b0;
      case (f)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[15:0]; cy = s[16];
            ov = (a[15] == b[15]) && (r[15] != a[15]);
         end
         4'd1: r = a & b;
         4'd2: begin
            s = {1'b0, a} + {1'b0, ~b} + 17'd1;
            r = s[15:0]; cy = s[16];
            ov = (a[15] != b[15]) && (r[15] != a[15]);
         end
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: begin r = a << 1; cy = a[15]; end
         default: r = a ^ (b + 16'(f));
      endcase
      return {ov, cy, r[15], (r == 16'd0), r};
   endfunction

   assign {fu_v, fu_c, fu_n, fu_z, fu_result} = fu_func(fu_fs, fu_opa, fu_opb);

   // Transaction-level model: schedule of edges computed at each accept
   int          t = 0;
   int          m_idle_from = 0;
   int          m_done_edge = -10;
   int          m_acc_edge  = -100;
   int          m_n = 0;
   bit          m_legal = 1'b0;
   bit          m_err = 1'b0;
   logic [3:0]  m_op = '0;
   logic [15:0] m_opa = '0;
   logic [15:0] m_bv [16];
   logic [19:0] m_final = '0;
   logic [19:0] m_res = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, t, act, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit rq, input logic [3:0] o,
                             input logic [15:0] a, input logic [15:0] b, input logic [3:0] cn);
      logic [15:0] bb;
      logic [19:0] f;
      if (r) begin
         m_idle_from = t + 1; m_done_edge = -10; m_acc_edge = -100;
         m_res = '0; m_err = 1'b0; m_legal = 1'b0; m_n = 0;
      end else begin
         if (t >= m_idle_from && rq) begin
            m_acc_edge = t; m_op = o; m_opa = a;
            m_legal = (o <= 4'd12); m_err = !m_legal; m_res = '0;
`ifdef FU_SEQ_ITER_EN
            m_n = (cn == 4'd0) ? 1 : int'(cn);
`else
            m_n = 1;
`endif
            if (m_legal) begin
               bb = b;
               f  = '0;
               for (int i = 0; i < m_n; i++) begin
                  m_bv[i] = bb;
                  f  = fu_func(o, a, bb);
                  bb = f[15:0];
               end
               m_final = f;
               m_done_edge = t + m_n;
               m_idle_from = t + m_n + 2;
            end else begin
               m_final = '0;
               m_done_edge = t;
               m_idle_from = t + 2;
            end
         end
         if (t == m_done_edge) m_res = m_final;
      end
   endtask

   task automatic compare_all();
      bit          in_exec;
      logic [35:0] exp_fu;
      in_exec = m_legal && (t >= m_acc_edge) && (t < m_acc_edge + m_n);
      exp_fu  = in_exec ? {m_op, m_opa, m_bv[t - m_acc_edge]} : {4'hF, 16'h0, 16'h0};
      chk("ready", 64'(ready), 64'(t + 1 >= m_idle_from));
      chk("done", 64'(done), 64'(t == m_done_edge));
      chk("err", 64'(err), 64'(m_err));
      chk("result_flags", 64'({v, c, n, z, result}), 64'(m_res));
      chk("fu_drive", 64'({fu_fs, fu_opa, fu_opb}), 64'(exp_fu));
   endtask

   // One clock: drive, let the edge happen, update model, compare away from the edge
   task automatic cyc(input bit r, input bit rq, input logic [3:0] o, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] cn);
      rst = r; req = rq; op = o; opa = a; opb = b; count = cn;
      @(posedge clk);
      t++;
      model_edge(r, rq, o, a, b, cn);
      #1;
      compare_all();
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom));
   endtask

   // Issue one op from IDLE, wait for done, pin latency and final outputs to literals
   task automatic do_op(input string name, input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] cn, input int exp_lat,
                        input logic [19:0] exp_res, input bit exp_err);
      int lat;
      idle();
      idle();
      cyc(1'b0, 1'b1, o, a, b, cn);
      lat = 1;
      while (!done && lat < 20) begin
         idle();
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({name, "_result"}, 64'({v, c, n, z, result}), 64'(exp_res));
      chk({name, "_err"}, 64'(err), 64'(exp_err));
   endtask

   initial begin
      cyc(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0);
      cyc(1'b1, 1'b0, 4'd0, 16'd0, 16'd0, 4'd0);
      chk("reset_ready", 64'(ready), 64'd1);
      chk("reset_fu_fs", 64'(fu_fs), 64'hF);
      chk("reset_result", 64'({v, c, n, z, result, done, err}), 64'd0);

      do_op("add_single", 4'd0, 16'h0003, 16'h0004, 4'd1, 2, 20'h00007, 1'b0);
`ifdef FU_SEQ_ITER_EN
      do_op("add_iter", 4'd0, 16'h0005, 16'h0001, 4'd3, 4, 20'h00010, 1'b0);
`else
      do_op("add_iter", 4'd0, 16'h0005, 16'h0001, 4'd3, 2, 20'h00006, 1'b0);
`endif
      do_op("sub_zero", 4'd2, 16'h0005, 16'h0005, 4'd1, 2, 20'h50000, 1'b0);
      do_op("illegal", 4'd13, 16'h1234, 16'h5678, 4'd2, 1, 20'h00000, 1'b1);
      do_op("legal_clears_err", 4'd1, 16'h00F0, 16'h0F30, 4'd0, 2, 20'h00030, 1'b0);

      // reset two edges after accept abandons the op
      idle();
      idle();
      cyc(1'b0, 1'b1, 4'd0, 16'h0011, 16'h0022, 4'd5);
      idle();
      cyc(1'b1, 1'b0, 4'd0, 16'h0, 16'h0, 4'd0);
      chk("rst_mid_ready", 64'(ready), 64'd1);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_result", 64'({v, c, n, z, result}), 64'd0);
      for (int i = 0; i < 8; i++) idle();

      // req held high, opa changing every cycle
      for (int i = 0; i < 60; i++)
         cyc(1'b0, 1'b1, 4'($urandom_range(0, 5)), 16'(i * 37 + 1), 16'($urandom), 4'($urandom));

      // random traffic with occasional resets and illegal ops
      for (int i = 0; i < 3000; i++)
         cyc(($urandom_range(0, 63) == 0), 1'($urandom), 4'($urandom), 16'($urandom),
             16'($urandom), 4'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
